// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: one-hot phase codes, Booth digit codes,
// multiplier FSM states and the radix-4 recoding helper.
package arith_pkg;

    localparam logic [2:0] PH_Q0 = 3'b001;
    localparam logic [2:0] PH_Q1 = 3'b010;
    localparam logic [2:0] PH_Q2 = 3'b100;

    typedef enum logic [2:0] {
        ZERO,
        PM,
        P2M,
        NM,
        N2M
    } booth_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Recodes the overlapping triplet {q[i+1], q[i], q[i-1]} into a digit in -2..+2
    function automatic booth_digit_t booth_decode(input logic [2:0] bits);
        booth_digit_t dig;
        case (bits)
            3'b001, 3'b010: dig = PM;
            3'b011:         dig = P2M;
            3'b100:         dig = N2M;
            3'b101, 3'b110: dig = NM;
            default:        dig = ZERO;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_r4_digit_sel.sv
// Combinational Booth digit selector: turns the current multiplier triplet and
// the multiplicand into the sign-extended W+2-bit addend.
module booth_r4_digit_sel #(
    parameter int W = 8
) (
    input  logic [2:0]   bits,
    input  logic [W-1:0] m,
    output logic [W+1:0] operand
);
    import arith_pkg::*;

    logic [W+1:0] m_ext;
    logic [W+1:0] m2_ext;

    // Two guard bits keep +/-2M representable without overflow
    assign m_ext  = {{2{m[W-1]}}, m};
    assign m2_ext = {m[W-1], m, 1'b0};

    always_comb begin
        operand = '0;
        case (booth_decode(bits))
            PM:      operand = m_ext;
            P2M:     operand = m2_ext;
            NM:      operand = '0 - m_ext;
            N2M:     operand = '0 - m2_ext;
            default: operand = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_phased_mult.sv
// Signed radix-4 Booth sequential multiplier stepped by an external one-hot
// three-phase counter (Q0 select, Q1 add, Q2 shift) for each Booth digit.
module booth_r4_phased_mult #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           begin_op,
    input  logic [2:0]     phase,
    input  logic [W-1:0]   multiplicand,
    input  logic [W-1:0]   multiplier,
    output logic [2*W-1:0] product,
    output logic           busy,
    output logic           done,
    output logic           phase_err
);
    import arith_pkg::*;

    localparam int IW = $clog2(W / 2);
    localparam logic [IW-1:0] LAST_ITER = IW'(W / 2 - 1);

    state_t         state_q,     state_d;
    logic [W+1:0]   a_q,         a_d;
    logic [W-1:0]   qr_q,        qr_d;
    logic           qm1_q,       qm1_d;
    logic [W-1:0]   m_q,         m_d;
    logic [W+1:0]   operand_q,   operand_d;
    logic [IW-1:0]  iter_q,      iter_d;
    logic [2:0]     exp_phase_q, exp_phase_d;
    logic [2*W-1:0] product_q,   product_d;
    logic           err_q,       err_d;

    logic [W+1:0]   sel_operand;
    logic [2*W+2:0] shift_vec;

    booth_r4_digit_sel #(
        .W (W)
    ) u_digit_sel (
        .bits    ({qr_q[1:0], qm1_q}),
        .m       (m_q),
        .operand (sel_operand)
    );

    // Arithmetic shift of the whole {A, Qr, q_m1} chain by one Booth digit
    assign shift_vec = $unsigned($signed({a_q, qr_q, qm1_q}) >>> 2);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        qr_d        = qr_q;
        qm1_d       = qm1_q;
        m_d         = m_q;
        operand_d   = operand_q;
        iter_d      = iter_q;
        exp_phase_d = exp_phase_q;
        product_d   = product_q;
        err_d       = err_q;

        // A start pulse wins in every state and silently drops any run in flight
        if (begin_op) begin
            state_d     = ST_RUN;
            a_d         = '0;
            qr_d        = multiplier;
            qm1_d       = 1'b0;
            m_d         = multiplicand;
            iter_d      = '0;
            exp_phase_d = PH_Q0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (phase != exp_phase_q) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        case (exp_phase_q)
                            PH_Q0: begin
                                operand_d   = sel_operand;
                                exp_phase_d = PH_Q1;
                            end
                            PH_Q1: begin
                                a_d         = a_q + operand_q;
                                exp_phase_d = PH_Q2;
                            end
                            PH_Q2: begin
                                a_d    = shift_vec[2*W+2:W+1];
                                qr_d   = shift_vec[W:1];
                                qm1_d  = shift_vec[0];
                                iter_d = iter_q + 1'b1;
                                if (iter_q == LAST_ITER) begin
                                    product_d = shift_vec[2*W:1];
                                    state_d   = ST_DONE;
                                end else begin
                                    exp_phase_d = PH_Q0;
                                end
                            end
                            default: begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            qr_q        <= '0;
            qm1_q       <= 1'b0;
            m_q         <= '0;
            operand_q   <= '0;
            iter_q      <= '0;
            exp_phase_q <= '0;
            product_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            qr_q        <= qr_d;
            qm1_q       <= qm1_d;
            m_q         <= m_d;
            operand_q   <= operand_d;
            iter_q      <= iter_d;
            exp_phase_q <= exp_phase_d;
            product_q   <= product_d;
            err_q       <= err_d;
        end
    end

    assign product   = product_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign phase_err = err_q;

endmodule

// File: tb/tb_booth_r4_phased_mult.sv
// Directed bench for booth_r4_phased_mult (W=8) with a local mod-3 one-hot
// phase counter that restarts on begin_op, plus a forcing override.
module tb_booth_r4_phased_mult;

    logic        clk;
    logic        reset;
    logic        begin_op;
    logic [2:0]  phase;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [15:0] product;
    logic        busy;
    logic        done;
    logic        phase_err;

    logic [2:0]  phase_cnt;
    logic        force_en;
    logic [2:0]  force_val;

    int checks;
    int failures;

    booth_r4_phased_mult #(
        .W (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .begin_op     (begin_op),
        .phase        (phase),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done),
        .phase_err    (phase_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase counter: Q0 is presented in the first cycle after begin_op
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            phase_cnt <= 3'b001;
        else if (begin_op)
            phase_cnt <= 3'b001;
        else
            phase_cnt <= {phase_cnt[1:0], phase_cnt[2]};
    end

    assign phase = force_en ? force_val : phase_cnt;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] ref_mult(input logic signed [7:0] a,
                                             input logic signed [7:0] b);
        logic signed [15:0] r;
        r = a * b;
        return r;
    endfunction

    // Drives one begin_op pulse; returns #1 after the begin_op edge
    task automatic apply_stimulus(input logic [7:0] m, input logic [7:0] q);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        begin_op     = 1'b1;
        @(posedge clk);
        #1;
        begin_op = 1'b0;
    endtask

    // Counts edges to done (0 if it never comes) and busy cycles before it
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = busy ? 1 : 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = e;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [7:0] m,
                                 input logic [7:0] q, input logic [15:0] expected);
        int edges;
        int busy_cycles;
        apply_stimulus(m, q);
        wait_done(edges, busy_cycles);
        check_output({tag, "_latency"}, edges, 12);
        check_output({tag, "_product"}, product, expected);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int edges;
        int busy_cycles;
        int done_seen;
        logic [7:0] vals [11];
        logic [7:0] rm;
        logic [7:0] rq;

        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        begin_op     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        force_en     = 1'b0;
        force_val    = 3'b000;
        vals = '{8'h80, 8'h81, 8'hFE, 8'hFF, 8'h00, 8'h01,
                 8'h02, 8'h3F, 8'h40, 8'h7E, 8'h7F};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("reset_product", product, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_phase_err", phase_err, 0);

        // 7 x -3 with full latency and busy-window checks
        apply_stimulus(8'd7, 8'hFD);
        check_output("m7_busy_at_start", busy, 1);
        wait_done(edges, busy_cycles);
        check_output("m7_latency", edges, 12);
        check_output("m7_product", product, 16'hFFEB);
        check_output("m7_busy_cycles", busy_cycles, 12);
        check_output("m7_busy_in_done", busy, 0);
        @(posedge clk);
        #1;
        check_output("m7_done_one_cycle", done, 0);
        check_output("m7_product_held", product, 16'hFFEB);

        run_and_check("neg128_sq", 8'h80, 8'h80, 16'h4000);
        run_and_check("pos127_sq", 8'h7F, 8'h7F, 16'h3F01);
        run_and_check("neg128_x_127", 8'h80, 8'h7F, 16'hC080);

        // Restart on the 5th cycle of a run: the first run must not complete
        apply_stimulus(8'd9, 8'd9);
        repeat (4) @(posedge clk);
        apply_stimulus(8'd3, 8'd5);
        wait_done(edges, busy_cycles);
        check_output("restart_latency", edges, 12);
        check_output("restart_product", product, 16'h000F);

        // Illegal phase on cycle 4 aborts the run
        apply_stimulus(8'd2, 8'd2);
        repeat (3) @(posedge clk);
        #1;
        force_val = 3'b011;
        force_en  = 1'b1;
        @(posedge clk);
        #1;
        force_en = 1'b0;
        check_output("abort_phase_err", phase_err, 1);
        check_output("abort_busy", busy, 0);
        check_output("abort_done", done, 0);
        done_seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check_output("abort_no_done", done_seen, 0);
        check_output("abort_product_kept", product, 16'h000F);
        check_output("abort_err_sticky", phase_err, 1);
        apply_stimulus(8'd6, 8'd7);
        check_output("begin_clears_err", phase_err, 0);
        wait_done(edges, busy_cycles);
        check_output("after_abort_latency", edges, 12);
        check_output("after_abort_product", product, 16'h002A);

        // Async reset mid-run takes effect without waiting for a clock edge
        apply_stimulus(8'd5, 8'd5);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("midreset_product", product, 0);
        check_output("midreset_busy", busy, 0);
        check_output("midreset_done", done, 0);
        check_output("midreset_phase_err", phase_err, 0);
        @(negedge clk);
        reset = 1'b0;
        run_and_check("post_reset", 8'hFB, 8'd11, 16'hFFC9);

        // Boundary operand cross-product and random pairs against the reference
        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < 11; j++) begin
                run_and_check($sformatf("corner_%0h_%0h", vals[i], vals[j]),
                              vals[i], vals[j], ref_mult(vals[i], vals[j]));
            end
        end
        for (int k = 0; k < 64; k++) begin
            rm = 8'($urandom_range(0, 255));
            rq = 8'($urandom_range(0, 255));
            run_and_check($sformatf("rand_%0h_%0h", rm, rq), rm, rq, ref_mult(rm, rq));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
